irq_latch_6: RTL and testbench

IRQ_LATCH_6 -- requirements
Module: irq_latch_6

---
 rtl/irq_latch_6.sv | 153 +++++++++++++++
 tb/tb_irq_latch_6.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_latch_6.sv
// -----------------------------------------------------------------------------
// irq_latch_6
//
// Six-source interrupt latch with a single-offer handshake.
//
// Each raw request line is brought into the clock domain through a two-flop
// synchronizer and optionally inverted (POLARITY_MASK) to give an active-high
// "norm" signal. Level sources follow norm directly; edge sources latch a
// rising edge of norm and hold it until the consumer acknowledges that
// source. The enable mask only hides sources from the outputs; latching
// continues underneath. A small IDLE/OFFER/RECOVER machine presents the
// highest-index pending source and holds that offer until it is acknowledged.
//
// Parameters
//   POLARITY_MASK : bit i = 1 -> source i is active-low
//   EDGE_MASK     : bit i = 1 -> source i is rising-edge triggered, else level
//
// Ports
//   clock        in   sole clock, rising edge
//   reset_n      in   synchronous active-low reset
//   req_in[5:0]  in   raw request lines, asynchronous to clock
//   enable_mask  in   per-source presentation enable
//   ack          in   consumer acknowledge of the current offer
//   pending[5:0] out  latched requests gated by enable_mask
//   any_pending  out  OR of pending
//   irq_valid    out  an offer is being presented
//   irq_id[2:0]  out  index of the offered source (0 when idle)
// -----------------------------------------------------------------------------
module irq_latch_6 #(
    parameter logic [5:0] POLARITY_MASK = 6'b000000,
    parameter logic [5:0] EDGE_MASK     = 6'b000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] req_in,
    input  logic [5:0] enable_mask,
    input  logic       ack,
    output logic [5:0] pending,
    output logic       any_pending,
    output logic       irq_valid,
    output logic [2:0] irq_id
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_prev;
    logic [5:0] r_raw_pend;
    state_t     r_state;
    logic       r_irq_valid;
    logic [2:0] r_irq_id;

    logic [5:0] w_norm;
    logic [5:0] w_rise;
    logic [5:0] w_clr;
    logic [5:0] w_raw_next;
    logic       w_ack_ok;
    logic [2:0] w_hi_id;

    assign w_norm   = r_sync2 ^ POLARITY_MASK;
    assign w_rise   = w_norm & ~r_prev;
    assign w_ack_ok = ack && (r_state == S_OFFER);

    // One-hot clear for the source being acknowledged; only edge sources use it.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < 6; i++) begin
            w_clr[i] = w_ack_ok && (r_irq_id == 3'(i));
        end
    end

    // Edge sources: a new rising edge beats a simultaneous clear.
    // Level sources simply track the normalized input.
    assign w_raw_next = (EDGE_MASK & (w_rise | (r_raw_pend & ~w_clr)))
                      | (~EDGE_MASK & w_norm);

    assign pending     = r_raw_pend & enable_mask;
    assign any_pending = |pending;
    assign irq_valid   = r_irq_valid;
    assign irq_id      = r_irq_id;

    // Highest-index visible source wins; ascending scan lets later bits override.
    always_comb begin
        w_hi_id = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (pending[i]) begin
                w_hi_id = 3'(i);
            end
        end
    end

    // Synchronizer, edge history and raw pending latch. Reset parks the
    // synchronizer at the inactive level so releasing reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1    <= POLARITY_MASK;
            r_sync2    <= POLARITY_MASK;
            r_prev     <= POLARITY_MASK;
            r_raw_pend <= '0;
        end else begin
            r_sync1    <= req_in;
            r_sync2    <= r_sync1;
            r_prev     <= w_norm;
            r_raw_pend <= w_raw_next;
        end
    end

    // Offer machine with registered outputs. The offered id is captured on
    // entry to OFFER and held regardless of what the source does afterwards.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_irq_valid <= 1'b0;
            r_irq_id    <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (any_pending) begin
                        r_state     <= S_OFFER;
                        r_irq_valid <= 1'b1;
                        r_irq_id    <= w_hi_id;
                    end else begin
                        r_irq_valid <= 1'b0;
                        r_irq_id    <= 3'd0;
                    end
                end
                S_OFFER: begin
                    if (ack) begin
                        r_state     <= S_RECOVER;
                        r_irq_valid <= 1'b0;
                        r_irq_id    <= 3'd0;
                    end
                end
                S_RECOVER: begin
                    r_state     <= S_IDLE;
                    r_irq_valid <= 1'b0;
                    r_irq_id    <= 3'd0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_irq_valid <= 1'b0;
                    r_irq_id    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_latch_6.sv
// -----------------------------------------------------------------------------
// tb_irq_latch_6
//
// Four instances of irq_latch_6 with different polarity/edge configurations
// share one clock. Directed sequences exercise the documented scenarios on
// instances 0..2, then all four receive random stimulus. A behavioural model
// (input history, per-source pending rules and a phase counter) predicts every
// output of every instance each cycle.
// -----------------------------------------------------------------------------
module tb_irq_latch_6;

    // Instance k uses bits [k*6 +: 6]
    localparam logic [23:0] POLS  = {6'b100110, 6'b000000, 6'b000001, 6'b000000};
    localparam logic [23:0] EDGES = {6'b011011, 6'b111111, 6'b000000, 6'b000000};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rstn [4];
    logic [5:0] req  [4];
    logic [5:0] en   [4];
    logic       ackv [4];
    logic [5:0] pend [4];
    logic       anyp [4];
    logic       vld  [4];
    logic [2:0] id   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        irq_latch_6 #(
            .POLARITY_MASK(POLS[g*6 +: 6]),
            .EDGE_MASK    (EDGES[g*6 +: 6])
        ) u_dut (
            .clock      (clock),
            .reset_n    (rstn[g]),
            .req_in     (req[g]),
            .enable_mask(en[g]),
            .ack        (ackv[g]),
            .pending    (pend[g]),
            .any_pending(anyp[g]),
            .irq_valid  (vld[g]),
            .irq_id     (id[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d] got %0h expected %0h at %0t", tag, k, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [5:0] m_h1   [4];   // last raw sample
    logic [5:0] m_h2   [4];   // sample before that
    logic [5:0] m_prev [4];
    logic [5:0] m_raw  [4];
    int         m_phase[4];   // 0 idle, 1 offering, 2 recovering
    int         m_id   [4];

    function automatic int highest(input logic [5:0] v);
        int h = 0;
        for (int i = 0; i < 6; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            logic [5:0] pol, edg, norm, nxt, vis;
            logic       accepted;
            pol = POLS[k*6 +: 6];
            edg = EDGES[k*6 +: 6];
            if (!rstn[k]) begin
                m_h1[k] = pol; m_h2[k] = pol; m_prev[k] = pol; m_raw[k] = '0;
                m_phase[k] = 0; m_id[k] = 0;
            end else begin
                norm     = m_h2[k] ^ pol;
                vis      = m_raw[k] & en[k];
                accepted = (m_phase[k] == 1) && ackv[k];
                for (int i = 0; i < 6; i++) begin
                    if (edg[i])
                        nxt[i] = (norm[i] && !m_prev[k][i]) ||
                                 (m_raw[k][i] && !(accepted && m_id[k] == i));
                    else
                        nxt[i] = norm[i];
                end
                if (m_phase[k] == 0) begin
                    if (vis != 0) begin m_phase[k] = 1; m_id[k] = highest(vis); end
                end else if (m_phase[k] == 1) begin
                    if (ackv[k]) begin m_phase[k] = 2; m_id[k] = 0; end
                end else begin
                    m_phase[k] = 0;
                end
                m_h2[k]   = m_h1[k];
                m_h1[k]   = req[k];
                m_prev[k] = norm;
                m_raw[k]  = nxt;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            logic [5:0] ep;
            ep = m_raw[k] & en[k];
            chk("pending",     k, {2'b00, pend[k]},  {2'b00, ep});
            chk("any_pending", k, {7'd0, anyp[k]},   {7'd0, (ep != 0)});
            chk("irq_valid",   k, {7'd0, vld[k]},    {7'd0, (m_phase[k] == 1)});
            chk("irq_id",      k, {5'd0, id[k]},     8'(m_id[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_offer(input int k, input int n);
        bit got = 1'b0;
        for (int i = 0; i < n && !got; i++) begin
            cycle();
            if (vld[k]) got = 1'b1;
        end
        chk("offer_seen", k, {7'd0, got}, 8'd1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rstn[k] = 1'b0; req[k] = 6'h00; en[k] = 6'h3F; ackv[k] = 1'b0;
        end
        req[1] = 6'h3F;     // active-low source 0 held inactive through reset
        en[1]  = 6'h01;
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            chk("rst_pending", k, {2'b00, pend[k]}, 8'h00);
            chk("rst_valid",   k, {7'd0, vld[k]},   8'h00);
            chk("rst_id",      k, {5'd0, id[k]},    8'h00);
            rstn[k] = 1'b1;
        end

        // Level source latency on instance 0
        cycle();
        req[0] = 6'h04;
        cycle();
        cycle();
        chk("lvl_early", 0, {2'b00, pend[0]}, 8'h00);
        cycle();
        chk("lvl_pend", 0, {2'b00, pend[0]}, 8'h04);
        chk("lvl_novld", 0, {7'd0, vld[0]}, 8'h00);
        cycle();
        chk("lvl_vld", 0, {7'd0, vld[0]}, 8'h01);
        chk("lvl_id",  0, {5'd0, id[0]},  8'h02);
        req[0] = 6'h00; ackv[0] = 1'b1;
        cycle();
        ackv[0] = 1'b0;
        repeat (8) cycle();

        // Active-low source on instance 1
        chk("al_idle", 1, {2'b00, pend[1]}, 8'h00);
        req[1] = 6'h3E;
        repeat (3) cycle();
        chk("al_pend", 1, {2'b00, pend[1]}, 8'h01);

        // Priority and ack on instance 2 (all edge)
        req[2] = 6'h21;
        cycle();
        req[2] = 6'h00;
        cycle();
        cycle();
        chk("pri_pend", 2, {2'b00, pend[2]}, 8'h21);
        cycle();
        chk("pri_vld", 2, {7'd0, vld[2]}, 8'h01);
        chk("pri_id5", 2, {5'd0, id[2]},  8'h05);
        ackv[2] = 1'b1;
        cycle();
        ackv[2] = 1'b0;
        chk("pri_rec", 2, {7'd0, vld[2]}, 8'h00);
        chk("pri_left", 2, {2'b00, pend[2]}, 8'h01);
        wait_offer(2, 4);
        chk("pri_id0", 2, {5'd0, id[2]}, 8'h00);
        ackv[2] = 1'b1;
        cycle();
        ackv[2] = 1'b0;
        chk("pri_clr", 2, {2'b00, pend[2]}, 8'h00);
        chk("pri_done", 2, {7'd0, vld[2]}, 8'h00);
        repeat (3) cycle();

        // Set wins over clear on instance 2
        req[2] = 6'h08;
        cycle();
        req[2] = 6'h00;
        repeat (3) cycle();
        chk("sw_id3", 2, {5'd0, id[2]}, 8'h03);
        req[2] = 6'h08;
        cycle();
        cycle();
        ackv[2] = 1'b1;
        cycle();
        ackv[2] = 1'b0; req[2] = 6'h00;
        chk("sw_pend", 2, {2'b00, pend[2]}, 8'h08);
        chk("sw_rec", 2, {7'd0, vld[2]}, 8'h00);
        wait_offer(2, 4);
        chk("sw_reoffer", 2, {5'd0, id[2]}, 8'h03);
        ackv[2] = 1'b1;
        cycle();
        ackv[2] = 1'b0;
        chk("sw_clr", 2, {2'b00, pend[2]}, 8'h00);
        repeat (3) cycle();

        // Masked edge source keeps latching on instance 2
        en[2] = 6'h3D; req[2] = 6'h02;
        cycle();
        req[2] = 6'h00;
        repeat (5) cycle();
        chk("msk_hidden", 2, {2'b00, pend[2]}, 8'h00);
        chk("msk_novld", 2, {7'd0, vld[2]}, 8'h00);
        en[2] = 6'h3F;
        #1;
        chk("msk_shown", 2, {2'b00, pend[2]}, 8'h02);
        cycle();
        chk("msk_vld", 2, {7'd0, vld[2]}, 8'h01);
        chk("msk_id1", 2, {5'd0, id[2]},  8'h01);
        ackv[2] = 1'b1;
        cycle();
        ackv[2] = 1'b0;
        repeat (3) cycle();

        // Reset mid-offer on instance 2
        req[2] = 6'h10;
        cycle();
        req[2] = 6'h00;
        repeat (3) cycle();
        chk("ro_vld", 2, {7'd0, vld[2]}, 8'h01);
        chk("ro_id4", 2, {5'd0, id[2]},  8'h04);
        rstn[2] = 1'b0;
        cycle();
        rstn[2] = 1'b1;
        chk("ro_novld", 2, {7'd0, vld[2]}, 8'h00);
        chk("ro_nopend", 2, {2'b00, pend[2]}, 8'h00);
        repeat (3) cycle();

        // Random traffic on all instances
        repeat (3000) begin
            for (int k = 0; k < 4; k++) begin
                req[k]  = 6'($urandom);
                en[k]   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
                ackv[k] = ($urandom_range(0, 2) == 0);
                rstn[k] = ($urandom_range(0, 63) != 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
